// File: rtl/input_conditioner_bank.sv
// Bank of independent input conditioners. Each channel synchronizes, debounces
// and edge-detects one asynchronous input, and a shared counter tallies every edge pulse.
module input_conditioner_bank #(
  parameter int                  CHANNELS     = 4,
  parameter int                  WAITTIME     = 3,
  parameter int                  COUNTERWIDTH = 3,
  parameter int                  SYNCSTAGES   = 2,
  parameter logic [CHANNELS-1:0] INITVAL      = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] noisysignal,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic                anyedge,
  output logic [7:0]          edgecount
);

  localparam logic [COUNTERWIDTH-1:0] WAIT_LIMIT = COUNTERWIDTH'(WAITTIME);

  logic [CHANNELS-1:0] pulse;
  logic [7:0]          pulse_count;
  logic [7:0]          edgecount_reg;
  logic [7:0]          edgecount_next;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNCSTAGES-1:0]   sync_reg;
      logic                    sync_last;
      logic                    cond_reg;
      logic                    pos_reg;
      logic                    neg_reg;
      logic [COUNTERWIDTH-1:0] count_reg;

      assign sync_last = sync_reg[SYNCSTAGES-1];

      // The chain keeps shifting even while debouncing is disabled.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_reg <= {SYNCSTAGES{INITVAL[gi]}};
        end else begin
          sync_reg <= {sync_reg[SYNCSTAGES-2:0], noisysignal[gi]};
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cond_reg  <= INITVAL[gi];
          count_reg <= '0;
          pos_reg   <= 1'b0;
          neg_reg   <= 1'b0;
        end else if (!enable || (sync_last == cond_reg)) begin
          count_reg <= '0;
          pos_reg   <= 1'b0;
          neg_reg   <= 1'b0;
        end else if (count_reg >= WAIT_LIMIT) begin
          // Mismatch has persisted past the wait window: accept the new level.
          cond_reg  <= sync_last;
          count_reg <= '0;
          pos_reg   <= sync_last;
          neg_reg   <= ~sync_last;
        end else begin
          count_reg <= count_reg + 1'b1;
          pos_reg   <= 1'b0;
          neg_reg   <= 1'b0;
        end
      end

      assign conditioned[gi]  = cond_reg;
      assign positiveedge[gi] = pos_reg;
      assign negativeedge[gi] = neg_reg;
    end
  endgenerate

  assign pulse   = positiveedge | negativeedge;
  assign anyedge = |pulse;

  always_comb begin
    pulse_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pulse_count = pulse_count + 8'(pulse[i]);
    end
  end

  // Tallies the registered pulses, so it trails them by one cycle and wraps freely.
  assign edgecount_next = edgecount_reg + pulse_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgecount_reg <= '0;
    end else begin
      edgecount_reg <= edgecount_next;
    end
  end

  assign edgecount = edgecount_reg;

endmodule

// File: tb/tb_input_conditioner_bank.sv
// Directed bench for input_conditioner_bank: latency, glitch rejection, simultaneous
// channels, reset mid-debounce, enable gating and edge counter wrap.
module tb_input_conditioner_bank;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] noisysignal;
  logic [3:0] conditioned;
  logic [3:0] positiveedge;
  logic [3:0] negativeedge;
  logic       anyedge;
  logic [7:0] edgecount;

  int vectors     = 0;
  int miscompares = 0;

  input_conditioner_bank #(
    .CHANNELS    (4),
    .WAITTIME    (3),
    .COUNTERWIDTH(3),
    .SYNCSTAGES  (2),
    .INITVAL     (4'b0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .noisysignal (noisysignal),
    .conditioned (conditioned),
    .positiveedge(positiveedge),
    .negativeedge(negativeedge),
    .anyedge     (anyedge),
    .edgecount   (edgecount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b1;
    noisysignal = 4'h0;
    #2 reset = 1'b1;
    #1;
    check("rst_cond", 32'(conditioned), 32'h0);
    check("rst_pos", 32'(positiveedge), 32'h0);
    check("rst_neg", 32'(negativeedge), 32'h0);
    check("rst_any", 32'(anyedge), 32'h0);
    check("rst_cnt", 32'(edgecount), 32'h0);
    tick();
    tick();
    check("rst_hold_cond", 32'(conditioned), 32'h0);
    reset = 1'b0;

    // Input equals INITVAL at release: no pulses
    for (int e = 0; e < 6; e++) begin
      tick();
      check("idle_any", 32'(anyedge), 32'h0);
      check("idle_cond", 32'(conditioned), 32'h0);
      check("idle_cnt", 32'(edgecount), 32'h0);
    end

    // Test 1: channel 0 rises, sampled at edge 0
    noisysignal[0] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      check("t1_cond", 32'(conditioned), (e >= 5) ? 32'h1 : 32'h0);
      check("t1_pos", 32'(positiveedge), (e == 5) ? 32'h1 : 32'h0);
      check("t1_neg", 32'(negativeedge), 32'h0);
      check("t1_any", 32'(anyedge), (e == 5) ? 32'h1 : 32'h0);
      check("t1_cnt", 32'(edgecount), (e >= 6) ? 32'h1 : 32'h0);
    end

    // Test 2a: 3-cycle glitch on channel 1 is rejected
    noisysignal[1] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (e == 2) noisysignal[1] = 1'b0;
      check("t2g_cond", 32'(conditioned), 32'h1);
      check("t2g_pos", 32'(positiveedge), 32'h0);
      check("t2g_neg", 32'(negativeedge), 32'h0);
    end

    // Test 2b: 4-cycle pulse on channel 1 passes, then falls back
    noisysignal[1] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 3) noisysignal[1] = 1'b0;
      check("t2p_cond", 32'(conditioned), (e >= 5 && e < 9) ? 32'h3 : 32'h1);
      check("t2p_pos", 32'(positiveedge), (e == 5) ? 32'h2 : 32'h0);
      check("t2p_neg", 32'(negativeedge), (e == 9) ? 32'h2 : 32'h0);
    end
    check("t2_cnt", 32'(edgecount), 32'h3);

    // Asynchronous reset clears state between clock edges
    noisysignal = 4'h0;
    reset = 1'b1;
    #1;
    check("arst_cond", 32'(conditioned), 32'h0);
    check("arst_cnt", 32'(edgecount), 32'h0);
    tick();
    reset = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      check("arst_any", 32'(anyedge), 32'h0);
    end

    // Test 3: all channels rise together, then fall together
    noisysignal = 4'hF;
    for (int e = 0; e < 14; e++) begin
      tick();
      if (e == 5) noisysignal = 4'h0;
      check("t3_cond", 32'(conditioned), (e >= 5 && e < 11) ? 32'hF : 32'h0);
      check("t3_pos", 32'(positiveedge), (e == 5) ? 32'hF : 32'h0);
      check("t3_neg", 32'(negativeedge), (e == 11) ? 32'hF : 32'h0);
      check("t3_cnt", 32'(edgecount), (e >= 12) ? 32'h8 : ((e >= 6) ? 32'h4 : 32'h0));
    end

    // Test 4: reset with channel 2 counter at 2
    noisysignal = 4'h4;
    for (int e = 0; e < 4; e++) begin
      tick();
      check("t4_pre_cond", 32'(conditioned), 32'h0);
    end
    reset = 1'b1;
    #1;
    check("t4_rst_cnt", 32'(edgecount), 32'h0);
    check("t4_rst_pos", 32'(positiveedge), 32'h0);
    tick();
    reset = 1'b0;
    for (int f = 0; f < 7; f++) begin
      tick();
      check("t4_cond", 32'(conditioned), (f >= 5) ? 32'h4 : 32'h0);
      check("t4_pos", 32'(positiveedge), (f == 5) ? 32'h4 : 32'h0);
      check("t4_cnt", 32'(edgecount), (f >= 6) ? 32'h1 : 32'h0);
    end

    // Test 5: enable low freezes channel 3 while it toggles
    enable      = 1'b0;
    noisysignal = 4'hC;
    for (int g = 0; g < 14; g++) begin
      tick();
      if (g == 3) noisysignal = 4'h4;
      if (g == 7) noisysignal = 4'hC;
      check("t5_off_cond", 32'(conditioned), 32'h4);
      check("t5_off_pos", 32'(positiveedge), 32'h0);
      check("t5_off_neg", 32'(negativeedge), 32'h0);
      check("t5_off_any", 32'(anyedge), 32'h0);
    end
    enable = 1'b1;
    for (int g = 0; g < 6; g++) begin
      tick();
      check("t5_on_cond", 32'(conditioned), (g >= 3) ? 32'hC : 32'h4);
      check("t5_on_pos", 32'(positiveedge), (g == 3) ? 32'h8 : 32'h0);
      check("t5_on_cnt", 32'(edgecount), (g >= 4) ? 32'h2 : 32'h1);
    end

    // Test 6: 130 full toggles on channel 0 wrap the edge counter to 4
    noisysignal = 4'h0;
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("t6_start_cnt", 32'(edgecount), 32'h0);
    for (int n = 0; n < 260; n++) begin
      noisysignal[0] = ~noisysignal[0];
      repeat (8) tick();
      check("t6_cond", 32'(conditioned), (n % 2 == 0) ? 32'h1 : 32'h0);
      check("t6_cnt", 32'(edgecount), 32'((n + 1) % 256));
    end
    check("t6_final_cnt", 32'(edgecount), 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_conditioner_bank.md
INPUT_CONDITIONER_BANK -- requirements
Module: input_conditioner_bank

Interface
REQ-001 The block SHALL have the following parameters.
- CHANNELS, default 4: number of independent input channels, 1..32.
- WAITTIME, default 3: debounce delay in clock cycles, at least 1.
- COUNTERWIDTH, default 3: counter width in bits; WAITTIME SHALL be at most 2^COUNTERWIDTH-1.
- SYNCSTAGES, default 2: synchronizer flops per channel, at least 2.
- INITVAL, default 0: CHANNELS-bit reset value for the synchronizer chains and conditioned.

REQ-002 The block SHALL have the following ports.
- clk, input, 1 bit: the single clock domain; all state updates on its posedge.
- reset, input, 1 bit: asynchronous, active-high.
- enable, input, 1 bit: debounce enable.
- noisysignal, input, CHANNELS bits: asynchronous raw inputs, one bit per channel.
- conditioned, output, CHANNELS bits: debounced levels.
- positiveedge, output, CHANNELS bits: one-cycle pulse on a rising transition of conditioned.
- negativeedge, output, CHANNELS bits: one-cycle pulse on a falling transition of conditioned.
- anyedge, output, 1 bit: OR of all positiveedge and negativeedge bits.
- edgecount, output, 8 bits: wrapping count of all edge pulses.

Function
REQ-003 Each channel SHALL be independent: its own SYNCSTAGES-deep synchronizer chain, its own COUNTERWIDTH-bit counter, and its own conditioned, positiveedge and negativeedge bits.
REQ-004 The synchronizer chain SHALL shift every cycle regardless of enable; sync[i] is the last stage.
REQ-005 While enable=1 and sync[i]==conditioned[i], the block SHALL clear counter[i] to 0 and drive positiveedge[i] and negativeedge[i] to 0 on the next cycle.
REQ-006 While enable=1, sync[i]!=conditioned[i] and counter[i]<WAITTIME, counter[i] SHALL increment by 1.
REQ-007 While enable=1, sync[i]!=conditioned[i] and counter[i]==WAITTIME, the block SHALL, on the same edge:
- set conditioned[i] to sync[i];
- clear counter[i] to 0;
- assert positiveedge[i] if the new value is 1, or negativeedge[i] if it is 0, for exactly one cycle.
REQ-008 Latency: an input level first sampled at clk edge k and held stable SHALL appear on conditioned[i], with its edge pulse, at edge k+SYNCSTAGES+WAITTIME.
REQ-009 A mismatch at sync[i] lasting at most WAITTIME consecutive cycles SHALL produce no change on conditioned[i] and no pulse; any matching cycle restarts the count from 0.
REQ-010 While enable=0, all counters SHALL hold at 0, conditioned SHALL hold its value, and all edge pulses SHALL be 0.
- Re-asserting enable SHALL start debounce from counter 0.
- The chain is not flushed.
REQ-011 positiveedge[i] and negativeedge[i] SHALL never be asserted in the same cycle, and neither SHALL be asserted for two consecutive cycles.
REQ-012 anyedge SHALL be a combinational OR of the registered pulse vectors, asserted in the same cycle as those pulses.
REQ-013 edgecount SHALL add the population count of (positiveedge|negativeedge) every cycle, modulo 256.
- It wraps 255 -> 0 with no saturation and no flag.
- It SHALL count correctly when several channels pulse in the same cycle.
REQ-014 Simultaneous transitions on multiple channels SHALL each be debounced and reported independently with the REQ-008 latency.

Reset
REQ-015 While reset=1, the block SHALL immediately force, independent of clk:
- all synchronizer stages = INITVAL;
- conditioned = INITVAL;
- counters = 0;
- positiveedge = negativeedge = 0;
- edgecount = 0.
REQ-016 Reset asserted mid-debounce SHALL discard the partial count and the pending transition; no pulse SHALL be generated for it after release.
REQ-017 With noisysignal equal to INITVAL at reset release, no edge pulse SHALL occur.
REQ-018 The first posedge after release SHALL operate normally.

Verification
REQ-019 Test 1: CHANNELS=4, SYNCSTAGES=2, WAITTIME=3, enable=1, INITVAL=0; noisysignal[0] goes 0->1 sampled at edge 0 and is held.
- conditioned[0]=1 and positiveedge[0]=1 at edge 5 only.
- anyedge=1 at edge 5.
- edgecount goes 0->1.
REQ-020 Test 2: 3-cycle high glitch on channel 1 -> no change on conditioned[1], no pulses; a 4-cycle high pulse -> positiveedge[1].
REQ-021 Test 3: channels 0..3 rise together, then fall together -> 4 simultaneous positiveedge pulses, then 4 negativeedge pulses; edgecount=8; no pulse overlaps its opposite.
REQ-022 Test 4: reset asserted at counter=2 on channel 2 with input held 1 -> outputs clear immediately; on release the channel re-debounces from 0 with full REQ-008 latency.
REQ-023 Test 5: enable=0 while channel 3 toggles stably -> conditioned[3] frozen, no pulses; enable=1 -> update WAITTIME+1 cycles later.
REQ-024 Test 6: 130 full toggles on channel 0 -> edgecount wraps to 4.
